// File: rtl/axis_tx_pkg.sv
// Shared definitions for the transmit framer: packet header bytes and FSM encodings.
// The header bytes are also used by the host-side decoder.
package axis_tx_pkg;

   localparam logic [7:0] HDR_SPIKE_BYTE = 8'hA0;
   localparam logic [7:0] HDR_RB_BYTE    = 8'hB0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_B1,
      ST_B2
   } tx_state_t;

   typedef enum logic {
      KIND_SPIKE,
      KIND_RB
   } pkt_kind_t;

endpackage

// File: rtl/axis_tx_fifo.sv
// Synchronous FIFO on a register array with first-word-fall-through head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axis_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A simultaneous pop frees the slot being written, so a full FIFO may still accept.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   assign head = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/axis_tx.sv
// Transmit framer: AER spike events and controller readback words are packed into
// header-tagged byte packets on an AXI-Stream master feeding the UART.
module axis_tx #(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] HDR_SPIKE  = axis_tx_pkg::HDR_SPIKE_BYTE,
   parameter logic [7:0] HDR_RB     = axis_tx_pkg::HDR_RB_BYTE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  AEROUT_ADDR,
   input  logic        AEROUT_REQ,
   output logic        AEROUT_ACK,
   input  logic [15:0] RB_DATA,
   input  logic        RB_VALID,
   output logic        RB_READY,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [15:0] SPIKE_CNT
);

   import axis_tx_pkg::*;

   logic       ack_reg;
   logic       aer_push;
   logic       fifo_pop;
   logic [7:0] fifo_head;
   logic       fifo_full;
   logic       fifo_empty;

   tx_state_t  state_reg,    state_next;
   pkt_kind_t  kind_reg,     kind_next;
   logic [7:0] addr_reg,     addr_next;
   logic [15:0] rb_reg,      rb_next;
   logic [7:0] tdata_reg,    tdata_next;
   logic       tvalid_reg,   tvalid_next;
   logic       rb_ready_reg, rb_ready_next;
   logic       cnt_inc;
   logic [15:0] spike_cnt_reg;

   // One push per request phase: a raised ACK blocks further pushes until REQ drops.
   assign aer_push = AEROUT_REQ && !ack_reg && !fifo_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_reg <= 1'b0;
      end else if (aer_push) begin
         ack_reg <= 1'b1;
      end else if (!AEROUT_REQ) begin
         ack_reg <= 1'b0;
      end
   end

   axis_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (aer_push),
      .din   (AEROUT_ADDR),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_next    = state_reg;
      kind_next     = kind_reg;
      addr_next     = addr_reg;
      rb_next       = rb_reg;
      tdata_next    = tdata_reg;
      tvalid_next   = tvalid_reg;
      rb_ready_next = 1'b0;
      fifo_pop      = 1'b0;
      cnt_inc       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Readback wins over queued spikes; IDLE always emits one bubble cycle.
            if (RB_VALID) begin
               rb_next       = RB_DATA;
               rb_ready_next = 1'b1;
               kind_next     = KIND_RB;
               tdata_next    = HDR_RB;
               tvalid_next   = 1'b1;
               state_next    = ST_HDR;
            end else if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               addr_next   = fifo_head;
               kind_next   = KIND_SPIKE;
               tdata_next  = HDR_SPIKE;
               tvalid_next = 1'b1;
               state_next  = ST_HDR;
            end
         end
         ST_HDR: begin
            if (m_axis_tready) begin
               tdata_next = (kind_reg == KIND_SPIKE) ? addr_reg : rb_reg[15:8];
               state_next = ST_B1;
            end
         end
         ST_B1: begin
            if (m_axis_tready) begin
               if (kind_reg == KIND_SPIKE) begin
                  tvalid_next = 1'b0;
                  cnt_inc     = 1'b1;
                  state_next  = ST_IDLE;
               end else begin
                  tdata_next = rb_reg[7:0];
                  state_next = ST_B2;
               end
            end
         end
         ST_B2: begin
            if (m_axis_tready) begin
               tvalid_next = 1'b0;
               state_next  = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         kind_reg     <= KIND_SPIKE;
         addr_reg     <= '0;
         rb_reg       <= '0;
         tdata_reg    <= '0;
         tvalid_reg   <= 1'b0;
         rb_ready_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         kind_reg     <= kind_next;
         addr_reg     <= addr_next;
         rb_reg       <= rb_next;
         tdata_reg    <= tdata_next;
         tvalid_reg   <= tvalid_next;
         rb_ready_reg <= rb_ready_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spike_cnt_reg <= '0;
      end else if (cnt_inc) begin
         spike_cnt_reg <= spike_cnt_reg + 16'd1;
      end
   end

   assign AEROUT_ACK    = ack_reg;
   assign RB_READY      = rb_ready_reg;
   assign m_axis_tdata  = tdata_reg;
   assign m_axis_tvalid = tvalid_reg;
   assign SPIKE_CNT     = spike_cnt_reg;

endmodule

// File: tb/tb_axis_tx.sv
// Self-checking bench for axis_tx: expected bytes are queued when stimulus is driven
// and popped by a stream monitor as the DUT hands bytes to the sink.
`timescale 1ns/1ps
module tb_axis_tx;

   localparam logic [7:0] H_SPIKE = 8'hA0;
   localparam logic [7:0] H_RB    = 8'hB0;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  AEROUT_ADDR;
   logic        AEROUT_REQ;
   logic        AEROUT_ACK;
   logic [15:0] RB_DATA;
   logic        RB_VALID;
   logic        RB_READY;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [15:0] SPIKE_CNT;

   int          tests = 0;
   int          fails = 0;
   int          exp_cnt = 0;
   logic [7:0]  exp_q [$];

   always #5 clk = ~clk;

   axis_tx #(
      .FIFO_DEPTH (16),
      .HDR_SPIKE  (8'hA0),
      .HDR_RB     (8'hB0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .AEROUT_ADDR   (AEROUT_ADDR),
      .AEROUT_REQ    (AEROUT_REQ),
      .AEROUT_ACK    (AEROUT_ACK),
      .RB_DATA       (RB_DATA),
      .RB_VALID      (RB_VALID),
      .RB_READY      (RB_READY),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .SPIKE_CNT     (SPIKE_CNT)
   );

   // Stream monitor: scoreboard compare, hold-under-stall and inter-packet bubble.
   initial begin
      logic       stall_prev;
      logic [7:0] stall_data;
      logic       need_bubble;
      int         rem;
      logic [7:0] e;
      stall_prev  = 1'b0;
      stall_data  = '0;
      need_bubble = 1'b0;
      rem         = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev  = 1'b0;
            need_bubble = 1'b0;
            rem         = 0;
         end else begin
            if (need_bubble) begin
               tests++;
               if (m_axis_tvalid !== 1'b0) begin
                  fails++;
                  $display("FAIL bubble: tvalid=%b required 0", m_axis_tvalid);
               end
               need_bubble = 1'b0;
            end
            if (stall_prev) begin
               tests++;
               if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_data) begin
                  fails++;
                  $display("FAIL hold: tvalid=%b tdata=%h required tvalid=1 tdata=%h",
                           m_axis_tvalid, m_axis_tdata, stall_data);
               end
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL stream_extra: got byte %h, none expected", m_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  if (m_axis_tdata !== e) begin
                     fails++;
                     $display("FAIL stream_byte: got %h required %h", m_axis_tdata, e);
                  end
               end
               $display("[TB] byte %h", m_axis_tdata);
               if (rem == 0) rem = (m_axis_tdata == H_RB) ? 2 : 1;
               else          rem = rem - 1;
               if (rem == 0) need_bubble = 1'b1;
            end
            stall_prev = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
            stall_data = m_axis_tdata;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic val, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (AEROUT_ACK === val) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send_spike(input logic [7:0] a, output bit ok);
      bit ok1, ok2;
      exp_q.push_back(H_SPIKE);
      exp_q.push_back(a);
      AEROUT_ADDR = a;
      AEROUT_REQ  = 1'b1;
      wait_ack(1'b1, ok1);
      step();
      AEROUT_REQ = 1'b0;
      wait_ack(1'b0, ok2);
      step();
      ok = ok1 && ok2;
   endtask

   task automatic drain(output bit ok);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      repeat (4) @(negedge clk);
      ok = (exp_q.size() == 0);
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      AEROUT_ADDR = '0; AEROUT_REQ = 1'b0;
      RB_DATA = '0; RB_VALID = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      tests++;
      if ({AEROUT_ACK, RB_READY, m_axis_tvalid, m_axis_tdata, SPIKE_CNT} !== 27'd0) begin
         fails++;
         $display("FAIL reset_state: ack=%b rb_ready=%b tvalid=%b tdata=%h cnt=%h required all 0",
                  AEROUT_ACK, RB_READY, m_axis_tvalid, m_axis_tdata, SPIKE_CNT);
      end
      step();
      rst = 1'b0;
      exp_cnt = 0;
      step();
   endtask

   task automatic test_single_spike();
      bit ok;
      m_axis_tready = 1'b1;
      exp_q.push_back(H_SPIKE);
      exp_q.push_back(8'h2C);
      AEROUT_ADDR = 8'h2C;
      AEROUT_REQ  = 1'b1;
      @(negedge clk);
      tests++;
      if (AEROUT_ACK !== 1'b0) begin fails++; $display("FAIL ack_before: ack=%b required 0", AEROUT_ACK); end
      step(); @(negedge clk);
      tests++;
      if (AEROUT_ACK !== 1'b1 || m_axis_tvalid !== 1'b0) begin
         fails++; $display("FAIL ack_rise: ack=%b tvalid=%b required ack=1 tvalid=0", AEROUT_ACK, m_axis_tvalid);
      end
      step(); @(negedge clk);
      tests++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== H_SPIKE) begin
         fails++; $display("FAIL hdr_latency: tvalid=%b tdata=%h required 1/%h", m_axis_tvalid, m_axis_tdata, H_SPIKE);
      end
      step();
      AEROUT_REQ = 1'b0;
      @(negedge clk);
      tests++;
      if (AEROUT_ACK !== 1'b1) begin fails++; $display("FAIL ack_hold: ack=%b required 1", AEROUT_ACK); end
      step(); @(negedge clk);
      tests++;
      if (AEROUT_ACK !== 1'b0) begin fails++; $display("FAIL ack_fall: ack=%b required 0", AEROUT_ACK); end
      exp_cnt++;
      drain(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL single_drain: %0d bytes outstanding required 0", exp_q.size()); end
      tests++;
      if (SPIKE_CNT !== 16'(exp_cnt)) begin fails++; $display("FAIL single_cnt: cnt=%0d required %0d", SPIKE_CNT, exp_cnt); end
   endtask

   task automatic test_rb_priority();
      bit ok;
      m_axis_tready = 1'b1;
      exp_q.push_back(H_RB);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      exp_q.push_back(H_SPIKE);
      exp_q.push_back(8'h05);
      AEROUT_ADDR = 8'h05;
      AEROUT_REQ  = 1'b1;
      step();
      RB_DATA  = 16'h1234;
      RB_VALID = 1'b1;
      @(negedge clk);
      tests++;
      if (RB_READY !== 1'b0) begin fails++; $display("FAIL rb_ready_early: rb_ready=%b required 0", RB_READY); end
      step();
      RB_VALID = 1'b0;
      @(negedge clk);
      tests++;
      if (RB_READY !== 1'b1 || m_axis_tdata !== H_RB) begin
         fails++; $display("FAIL rb_priority: rb_ready=%b tdata=%h required 1/%h", RB_READY, m_axis_tdata, H_RB);
      end
      step(); @(negedge clk);
      tests++;
      if (RB_READY !== 1'b0) begin fails++; $display("FAIL rb_pulse: rb_ready=%b required 0", RB_READY); end
      step();
      AEROUT_REQ = 1'b0;
      wait_ack(1'b0, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rb_ack_timeout: ack=%b required 0", AEROUT_ACK); end
      exp_cnt++;
      drain(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rb_drain: %0d bytes outstanding required 0", exp_q.size()); end
      tests++;
      if (SPIKE_CNT !== 16'(exp_cnt)) begin fails++; $display("FAIL rb_cnt: cnt=%0d required %0d", SPIKE_CNT, exp_cnt); end
   endtask

   task automatic test_stream_backpressure();
      bit ok;
      m_axis_tready = 1'b0;
      send_spike(8'h77, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bp_handshake: ack timeout, required handshake"); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== H_SPIKE) begin
            fails++; $display("FAIL bp_stall: tvalid=%b tdata=%h required 1/%h", m_axis_tvalid, m_axis_tdata, H_SPIKE);
         end
         step();
      end
      m_axis_tready = 1'b1;
      exp_cnt++;
      drain(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bp_drain: %0d bytes outstanding required 0", exp_q.size()); end
      tests++;
      if (SPIKE_CNT !== 16'(exp_cnt)) begin fails++; $display("FAIL bp_cnt: cnt=%0d required %0d", SPIKE_CNT, exp_cnt); end
   endtask

   task automatic test_fifo_full();
      bit ok, all_ok, seen;
      m_axis_tready = 1'b0;
      exp_q.push_back(H_RB);
      exp_q.push_back(8'hCA);
      exp_q.push_back(8'hFE);
      RB_DATA  = 16'hCAFE;
      RB_VALID = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (RB_READY === 1'b1) begin seen = 1'b1; break; end
      end
      step();
      RB_VALID = 1'b0;
      tests++;
      if (!seen) begin fails++; $display("FAIL full_rb_ready: rb_ready never pulsed, required pulse"); end
      all_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send_spike(8'(i), ok);
         all_ok = all_ok && ok;
      end
      tests++;
      if (!all_ok) begin fails++; $display("FAIL full_fill: ack timeout while filling, required 16 handshakes"); end
      exp_q.push_back(H_SPIKE);
      exp_q.push_back(8'h10);
      AEROUT_ADDR = 8'h10;
      AEROUT_REQ  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (AEROUT_ACK !== 1'b0) begin fails++; $display("FAIL full_no_ack: ack=%b required 0", AEROUT_ACK); end
         step();
      end
      m_axis_tready = 1'b1;
      wait_ack(1'b1, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL full_ack_after_pop: ack=%b required 1", AEROUT_ACK); end
      step();
      AEROUT_REQ = 1'b0;
      wait_ack(1'b0, ok);
      step();
      exp_cnt += 17;
      drain(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL full_drain: %0d bytes outstanding required 0", exp_q.size()); end
      tests++;
      if (SPIKE_CNT !== 16'(exp_cnt)) begin fails++; $display("FAIL full_cnt: cnt=%0d required %0d", SPIKE_CNT, exp_cnt); end
   endtask

   task automatic test_reset_mid_packet();
      bit ok, seen;
      m_axis_tready = 1'b1;
      exp_q.push_back(H_RB);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h5A);
      RB_DATA  = 16'h5A5A;
      RB_VALID = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (RB_READY === 1'b1) begin seen = 1'b1; break; end
      end
      RB_VALID = 1'b0;
      tests++;
      if (!seen) begin fails++; $display("FAIL mid_rb_ready: rb_ready never pulsed, required pulse"); end
      step();
      rst = 1'b1;
      exp_q.delete();
      step();
      @(negedge clk);
      tests++;
      if (m_axis_tvalid !== 1'b0 || SPIKE_CNT !== 16'd0) begin
         fails++; $display("FAIL mid_reset: tvalid=%b cnt=%0d required 0/0", m_axis_tvalid, SPIKE_CNT);
      end
      step();
      rst = 1'b0;
      exp_cnt = 0;
      step();
      send_spike(8'h3C, ok);
      exp_cnt++;
      drain(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL mid_drain: %0d bytes outstanding required 0", exp_q.size()); end
      tests++;
      if (SPIKE_CNT !== 16'(exp_cnt)) begin fails++; $display("FAIL mid_cnt: cnt=%0d required %0d", SPIKE_CNT, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_spike(8'(8'h11 * (i + 1)), ok);
         exp_cnt++;
      end
      drain(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL b2b_drain: %0d bytes outstanding required 0", exp_q.size()); end
      tests++;
      if (SPIKE_CNT !== 16'(exp_cnt)) begin fails++; $display("FAIL b2b_cnt: cnt=%0d required %0d", SPIKE_CNT, exp_cnt); end
   endtask

   task automatic test_counter_wrap();
      bit ok;
      m_axis_tready = 1'b1;
      force dut.spike_cnt_reg = 16'hFFFF;
      step();
      release dut.spike_cnt_reg;
      @(negedge clk);
      tests++;
      if (SPIKE_CNT !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: cnt=%h required ffff", SPIKE_CNT); end
      step();
      send_spike(8'h99, ok);
      drain(ok);
      tests++;
      if (SPIKE_CNT !== 16'h0000) begin fails++; $display("FAIL wrap: cnt=%h required 0000", SPIKE_CNT); end
   endtask

   initial begin
      test_reset();
      test_single_spike();
      test_rb_priority();
      test_stream_backpressure();
      test_fifo_full();
      test_reset_mid_packet();
      test_back_to_back();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
